// File: rtl/sprite_load_pkg.sv
// Shared types and command codes for the sprite BRAM loader/arbiter.
package sprite_load_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PAL_LOAD = 3'd1,
    IMG_LOAD = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [7:0] CMD_PAL = 8'hA5;
  localparam logic [7:0] CMD_IMG = 8'h5A;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pal_entry_t;

endpackage

// File: rtl/sprite_port_hold.sv
// Keeps display ownership of the BRAM ports for HOLD_STAGES cycles after active falls.
module sprite_port_hold #(
  parameter int HOLD_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic hold
);

  logic [HOLD_STAGES-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else begin
      hist <= (hist << 1) | HOLD_STAGES'(active);
    end
  end

  assign hold = active | (|hist);

endmodule

// File: rtl/sprite_bram_load_arbiter.sv
// Shares image/palette BRAM ports between the display read path and a framed byte-stream loader.
// Optional build macro SPRITE_LOAD_CHECKSUM_EN adds a trailing 8-bit sum byte to every load.
module sprite_bram_load_arbiter #(
  parameter int         IMG_DEPTH   = 65536,
  parameter int         PAL_DEPTH   = 256,
  parameter int         HOLD_STAGES = 2,
  parameter logic [7:0] CMD_PAL     = sprite_load_pkg::CMD_PAL,
  parameter logic [7:0] CMD_IMG     = sprite_load_pkg::CMD_IMG
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        disp_active_in,
  input  logic [15:0] disp_img_addr_in,
  input  logic [7:0]  disp_pal_addr_in,
  input  logic [7:0]  s_data_in,
  input  logic        s_valid_in,
  output logic        s_ready_out,
  output logic [15:0] img_addr_out,
  output logic [7:0]  img_din_out,
  output logic        img_we_out,
  output logic [7:0]  pal_addr_out,
  output logic [23:0] pal_din_out,
  output logic        pal_we_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);
  import sprite_load_pkg::*;

  localparam int IW = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;
  localparam int PW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam logic [IW-1:0] IMG_LAST = IW'(IMG_DEPTH - 1);
  localparam logic [PW-1:0] PAL_LAST = PW'(PAL_DEPTH - 1);
`ifdef SPRITE_LOAD_CHECKSUM_EN
  localparam state_t LOAD_END = CHECK;
`else
  localparam state_t LOAD_END = DONE;
`endif

  state_t      state;
  logic [IW-1:0] img_cnt;
  logic [PW-1:0] pal_cnt;
  logic [1:0]  phase;
  logic [7:0]  r_q;
  logic [7:0]  g_q;
  logic        run_q;
  logic        err_q;
  logic        hold;
  logic        ready;
  logic        accept;
  pal_entry_t  wr_entry;
`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  sprite_port_hold #(
    .HOLD_STAGES(HOLD_STAGES)
  ) u_hold (
    .clk    (pixel_clk_in),
    .rst_n  (rst_n_in),
    .active (disp_active_in),
    .hold   (hold)
  );

  // run_q keeps ready low during and right after reset, even though IDLE accepts commands.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:                      ready = run_q;
      PAL_LOAD, IMG_LOAD, CHECK: ready = !hold;
      default:                   ready = 1'b0;
    endcase
  end

  assign accept      = s_valid_in & ready;
  assign s_ready_out = ready;

  assign wr_entry     = '{r: r_q, g: g_q, b: s_data_in};
  assign img_din_out  = s_data_in;
  assign pal_din_out  = wr_entry;
  assign img_we_out   = accept && (state == IMG_LOAD);
  assign pal_we_out   = accept && (state == PAL_LOAD) && (phase == 2'd2);
  assign img_addr_out = hold ? disp_img_addr_in : 16'(img_cnt);
  assign pal_addr_out = hold ? disp_pal_addr_in : 8'(pal_cnt);

  assign busy_out = (state == PAL_LOAD) || (state == IMG_LOAD);
  assign done_out = (state == DONE);
  assign err_out  = err_q;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      img_cnt <= '0;
      pal_cnt <= '0;
      phase   <= 2'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPRITE_LOAD_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      run_q <= 1'b1;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
`ifdef SPRITE_LOAD_CHECKSUM_EN
          sum_q <= 8'd0;
`endif
          if (accept) begin
            if (s_data_in == CMD_PAL)      state <= PAL_LOAD;
            else if (s_data_in == CMD_IMG) state <= IMG_LOAD;
            else                           err_q <= 1'b1;
          end
        end
        IMG_LOAD: begin
          if (accept) begin
`ifdef SPRITE_LOAD_CHECKSUM_EN
            sum_q <= sum_q + s_data_in;
`endif
            if (img_cnt == IMG_LAST) state <= LOAD_END;
            else                     img_cnt <= img_cnt + 1'b1;
          end
        end
        PAL_LOAD: begin
          // R and G are staged; a hold between bytes leaves them untouched.
          if (accept) begin
`ifdef SPRITE_LOAD_CHECKSUM_EN
            sum_q <= sum_q + s_data_in;
`endif
            case (phase)
              2'd0: begin
                r_q   <= s_data_in;
                phase <= 2'd1;
              end
              2'd1: begin
                g_q   <= s_data_in;
                phase <= 2'd2;
              end
              default: begin
                phase <= 2'd0;
                if (pal_cnt == PAL_LAST) state <= LOAD_END;
                else                     pal_cnt <= pal_cnt + 1'b1;
              end
            endcase
          end
        end
`ifdef SPRITE_LOAD_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            img_cnt <= '0;
            pal_cnt <= '0;
            if (s_data_in == sum_q) begin
              state <= DONE;
            end else begin
              state <= IDLE;
              err_q <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          img_cnt <= '0;
          pal_cnt <= '0;
          phase   <= 2'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_bram_load_arbiter.sv
// Scoreboard bench: stimulus queues expected BRAM writes and done/err events, a monitor pops them.
module tb_sprite_bram_load_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_active;
  logic [15:0] disp_img_addr;
  logic [7:0]  disp_pal_addr;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] img_addr;
  logic [7:0]  img_din;
  logic        img_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_din;
  logic        pal_we;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  sprite_bram_load_arbiter #(
    .IMG_DEPTH(16),
    .PAL_DEPTH(4),
    .HOLD_STAGES(2)
  ) dut (
    .pixel_clk_in     (clk),
    .rst_n_in         (rst_n),
    .disp_active_in   (disp_active),
    .disp_img_addr_in (disp_img_addr),
    .disp_pal_addr_in (disp_pal_addr),
    .s_data_in        (s_data),
    .s_valid_in       (s_valid),
    .s_ready_out      (s_ready),
    .img_addr_out     (img_addr),
    .img_din_out      (img_din),
    .img_we_out       (img_we),
    .pal_addr_out     (pal_addr),
    .pal_din_out      (pal_din),
    .pal_we_out       (pal_we),
    .busy_out         (busy),
    .done_out         (done),
    .err_out          (err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t        img_q[$];
  wr_t        pal_q[$];
  byte        ev_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  // Monitor: every write/done/err strobe must match the head of its queue.
  initial begin
    wr_t w;
    byte e;
    forever begin
      @(negedge clk);
      if (img_we) begin
        if (img_q.size() == 0) unexpected("img_write_unexpected");
        else begin
          w = img_q.pop_front();
          check("img_we_addr", {16'd0, img_addr}, {16'd0, w.addr});
          check("img_we_data", {24'd0, img_din}, {8'd0, w.data});
        end
      end
      if (pal_we) begin
        if (pal_q.size() == 0) unexpected("pal_write_unexpected");
        else begin
          w = pal_q.pop_front();
          check("pal_we_addr", {24'd0, pal_addr}, {16'd0, w.addr});
          check("pal_we_data", {8'd0, pal_din}, {8'd0, w.data});
        end
      end
      if (done) begin
        if (ev_q.size() == 0) unexpected("done_unexpected");
        else begin
          e = ev_q.pop_front();
          check("done_event", {24'd0, 8'(e)}, 32'h44);
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      if (err) begin
        if (ev_q.size() == 0) unexpected("err_unexpected");
        else begin
          e = ev_q.pop_front();
          check("err_event", {24'd0, 8'(e)}, 32'h45);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      $display("FAIL send_timeout actual=ready_low required=ready_high byte=%0h", b);
      $fatal(1, "stream stalled");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_sum(input logic [7:0] s);
`ifdef SPRITE_LOAD_CHECKSUM_EN
    send_byte(s);
`else
    if (s === 8'hxx) $display("unused");
`endif
  endtask

  task automatic image_load(input int nbytes);
    sum = 8'd0;
    send_byte(8'h5A);
    for (int i = 0; i < nbytes; i++) begin
      img_q.push_back('{addr: 16'(i), data: 24'(8'(i * 7 + 3))});
      sum = sum + 8'(i * 7 + 3);
      send_byte(8'(i * 7 + 3));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    disp_active   = 1'b0;
    disp_img_addr = 16'h0;
    disp_pal_addr = 8'h0;
    s_data        = 8'h5A;
    s_valid       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_img_we", {31'd0, img_we}, 32'd0);
    check("rst_pal_we", {31'd0, pal_we}, 32'd0);
    check("rst_img_addr", {16'd0, img_addr}, 32'd0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full image load, continuous stream.
    image_load(16);
    ev_q.push_back(8'h44);
    send_sum(sum);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_img", {31'd0, busy}, 32'd0);

    // Palette load with a display hold in the middle of entry 1.
    ev_q.push_back(8'h44);
    sum = 8'd0;
    send_byte(8'hA5);
    for (int e = 0; e < 4; e++) begin
      pal_q.push_back('{addr: 16'(e), data: {8'(8'h10 + 3 * e), 8'(8'h11 + 3 * e), 8'(8'h12 + 3 * e)}});
      for (int k = 0; k < 3; k++) begin
        sum = sum + 8'(8'h10 + 3 * e + k);
        if (e == 1 && k == 2) begin
          s_data      = 8'(8'h12 + 3 * e);
          s_valid     = 1'b1;
          disp_active = 1'b1;
          for (int h = 0; h < 3; h++) begin
            disp_pal_addr = 8'hE0 + 8'(h);
            @(negedge clk);
            check("pal_hold_ready", {31'd0, s_ready}, 32'd0);
            check("pal_hold_addr", {24'd0, pal_addr}, {24'd0, disp_pal_addr});
            @(posedge clk);
            #1;
          end
          disp_active = 1'b0;
        end
        send_byte(8'(8'h10 + 3 * e + k));
      end
    end
    send_sum(sum);
    repeat (3) @(posedge clk);
    #1;

    // Bad command in IDLE.
    ev_q.push_back(8'h45);
    send_byte(8'h33);
    repeat (3) @(posedge clk);
    #1;
    check("bad_cmd_busy", {31'd0, busy}, 32'd0);

    // Image load with display active for five cycles mid-stream.
    ev_q.push_back(8'h44);
    sum = 8'd0;
    for (int i = 0; i < 16; i++) begin
      img_q.push_back('{addr: 16'(i), data: 24'(8'(i * 7 + 3))});
      sum = sum + 8'(i * 7 + 3);
    end
    fork
      begin
        send_byte(8'h5A);
        for (int i = 0; i < 16; i++) send_byte(8'(i * 7 + 3));
        send_sum(sum);
      end
      begin
        repeat (5) @(posedge clk);
        for (int k = 0; k < 7; k++) begin
          #1;
          disp_active   = (k < 5);
          disp_img_addr = 16'hA000 + 16'(k);
          disp_pal_addr = 8'hC0 + 8'(k);
          @(negedge clk);
          check("hold_ready_low", {31'd0, s_ready}, 32'd0);
          check("hold_img_addr", {16'd0, img_addr}, {16'd0, disp_img_addr});
          check("hold_pal_addr", {24'd0, pal_addr}, {24'd0, disp_pal_addr});
          @(posedge clk);
        end
        @(negedge clk);
        check("hold_release_ready", {31'd0, s_ready}, 32'd1);
        check("hold_release_addr", {16'd0, img_addr}, 32'd4);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an image load, then a clean reload.
    image_load(8);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, s_ready}, 32'd0);
    check("midrst_img_addr", {16'd0, img_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ev_q.push_back(8'h44);
    image_load(16);
    send_sum(sum);
    repeat (3) @(posedge clk);
    #1;

`ifdef SPRITE_LOAD_CHECKSUM_EN
    // Wrong checksum: writes land, err pulses, no done.
    ev_q.push_back(8'h45);
    image_load(16);
    send_byte(sum + 8'd1);
    repeat (3) @(posedge clk);
    #1;
    check("badsum_busy", {31'd0, busy}, 32'd0);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("img_q_drained", img_q.size(), 32'd0);
    check("pal_q_drained", pal_q.size(), 32'd0);
    check("ev_q_drained", ev_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_bram_load_arbiter.md
Name: sprite_bram_load_arbiter

Overview:
- Shares the single-port sprite image BRAM (8-bit palette index) and the palette BRAM (24-bit RGB) between two users: the display read path and a byte-stream loader.
- Display reads always have priority. The loader only gets the ports while the display pipeline is idle.
- The loader parses framed commands from a valid/ready byte stream (UART or host bridge), so image and palette contents can be replaced at runtime without a bitstream rebuild.

Parameters:
- IMG_DEPTH, 65536, image BRAM entries (bytes per image load).
- PAL_DEPTH, 256, palette entries (3 bytes each per palette load).
- HOLD_STAGES, 2, cycles the display keeps port ownership after disp_active_in falls (covers image-to-palette read latency).
- CMD_PAL, 8'hA5, command byte that starts a palette load.
- CMD_IMG, 8'h5A, command byte that starts an image load.

Ports:
- pixel_clk_in  in  1  the single clock
- rst_n_in  in  1  asynchronous, active-low reset
- disp_active_in  in  1  display needs the ports (sprite window active)
- disp_img_addr_in  in  16  display image-read address
- disp_pal_addr_in  in  8  display palette-read address (image BRAM output)
- s_data_in  in  8  loader stream byte
- s_valid_in  in  1  loader byte valid
- s_ready_out  out  1  loader byte accepted when high together with s_valid_in
- img_addr_out  out  16  image BRAM address
- img_din_out  out  8  image BRAM write data
- img_we_out  out  1  image BRAM write enable
- pal_addr_out  out  8  palette BRAM address
- pal_din_out  out  24  palette BRAM write data {R,G,B}
- pal_we_out  out  1  palette BRAM write enable
- busy_out  out  1  a load is in progress
- done_out  out  1  one-cycle pulse when a load completes
- err_out  out  1  one-cycle pulse on a bad command (or checksum error)

Behaviour:
- Reset values: state IDLE; counters 0; byte staging 0; hold shift register 0; s_ready_out 0; busy_out, done_out, err_out, img_we_out, pal_we_out all 0.
- Port ownership:
  - hold = disp_active_in OR any bit of a HOLD_STAGES-deep shift register of past disp_active_in values.
  - While hold is 1, img_addr_out = disp_img_addr_in and pal_addr_out = disp_pal_addr_in.
  - While hold is 0, the loader's address counters drive both addresses.
- Ready rule:
  - In IDLE: s_ready_out = 1 (command bytes are always accepted, no BRAM access).
  - In PAL_LOAD / IMG_LOAD: s_ready_out = !hold.
- Write timing:
  - A write has zero latency: we = s_valid_in & s_ready_out in the same cycle as the byte is accepted.
  - This means a write can never overlap a display read.
- State machine:
  - IDLE:
    - Accepted CMD_PAL → PAL_LOAD.
    - Accepted CMD_IMG → IMG_LOAD.
    - Any other accepted byte: dropped, err_out pulses, stay in IDLE.
  - IMG_LOAD:
    - Each accepted byte: img_din_out = s_data_in, img_we_out = 1, address counter increments.
    - Accepting byte IMG_DEPTH-1 → DONE.
  - PAL_LOAD:
    - Bytes arrive as R, then G, then B.
    - R and G are registered; no write occurs for them.
    - On B: pal_din_out = {R_q, G_q, s_data_in}, pal_we_out = 1, entry counter increments.
    - Accepting the B byte of entry PAL_DEPTH-1 → DONE.
  - DONE: done_out = 1 for exactly one cycle, counters clear, → IDLE.
- busy_out = 1 in PAL_LOAD and IMG_LOAD only.
- Boundary conditions:
  - hold rising in the middle of a palette triple: R_q/G_q are kept and the triple resumes once hold clears.
  - s_valid_in low: no state change.
  - Counters never wrap inside a load; the last address is written exactly once.
  - Reset mid-load: immediate return to IDLE. Partial BRAM contents are left as-is, with no done_out or err_out.
- Width rules: counters are $clog2(IMG_DEPTH) and $clog2(PAL_DEPTH) bits wide; the palette byte-phase counter is 2 bits (0..2).

Optional Feature:
- SPRITE_LOAD_CHECKSUM_EN:
  - Defined: after the last payload byte the FSM enters CHECK and accepts one more byte, under the same ready rule as payload bytes.
  - The expected value is the 8-bit modular sum of all payload bytes.
  - Match → DONE (done_out pulses). Mismatch → err_out pulses, no done_out, → IDLE.
- Not defined: no CHECK state; the last payload byte goes directly to DONE.

Decomposition:
- Package sprite_load_pkg:
  - state enum (IDLE, PAL_LOAD, IMG_LOAD, CHECK, DONE);
  - CMD_PAL and CMD_IMG localparams;
  - pal_entry_t packed struct {r, g, b}.
- One sub-module: sprite_port_hold, the HOLD_STAGES shift register plus the OR reduction that produces hold.

Test Plan:
- IMG_DEPTH=16, disp_active_in=0, stream 5A then 00..0F continuously → 16 cycles with img_we_out=1 and addresses 0..15; done_out pulses once; busy_out falls the same cycle.
- PAL_DEPTH=4, stream A5 then 12 bytes → pal_we_out only on every 3rd byte; entry 0 = 24'h{b0,b1,b2}; 4 writes total; then done_out.
- Image load with disp_active_in high for cycles 5–9 → s_ready_out low cycles 5–11 (HOLD_STAGES=2); addresses follow the disp_* inputs there; no write is lost or duplicated.
- Byte 8'h33 in IDLE → err_out pulse, state stays IDLE, no writes.
- rst_n_in low mid image load (address 7), then 5A + 16 bytes → restarts at address 0; exactly one done_out.
- With SPRITE_LOAD_CHECKSUM_EN: payload 01,02,03 (IMG_DEPTH=3) then checksum 06 → done_out; a second run with checksum 07 → err_out and no done_out.
